// File: rtl/riscv_alu_pkg.sv
// Shared types for the ALU issue path: ALU control codes, the RISC-V
// opcodes the issue stage understands, and the issue entry that travels
// from decode through the skid buffer to the EX stage.
package riscv_alu_pkg;

   // Width of the operand fields carried in an issue entry.
   localparam int ENTRY_XLEN = 64;

   typedef enum logic [3:0] {
      AND = 4'b0000,
      OR  = 4'b0001,
      ADD = 4'b0010,
      SUB = 4'b0110
   } alu_ctrl_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // ctrl is a plain 4-bit field so it can also hold the illegal code.
   typedef struct packed {
      logic [ENTRY_XLEN-1:0] x;
      logic [ENTRY_XLEN-1:0] y;
      logic [3:0]            ctrl;
      logic                  illegal;
   } issue_entry_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of a RISC-V instruction into an ALU issue entry:
// picks the ALU control code and selects operand y as rs2 or a
// sign-extended immediate. Undecodable instructions produce the illegal
// control code with y forced to zero; they are flagged, not dropped.
module alu_ctrl_decode
   import riscv_alu_pkg::*;
#(
   parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
   input  logic [31:0]           instr,
   input  logic [ENTRY_XLEN-1:0] rs1,
   input  logic [ENTRY_XLEN-1:0] rs2,
   output issue_entry_t          entry
);

   logic [6:0]                   opcode;
   logic [2:0]                   funct3;
   logic [6:0]                   funct7;
   logic signed [11:0]           imm_i;
   logic signed [11:0]           imm_s;
   logic signed [ENTRY_XLEN-1:0] imm_i_sx;
   logic signed [ENTRY_XLEN-1:0] imm_s_sx;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7   = instr[31:25];
   assign imm_i    = instr[31:20];
   assign imm_s    = {instr[31:25], instr[11:7]};
   assign imm_i_sx = {{(ENTRY_XLEN-12){imm_i[11]}}, imm_i};
   assign imm_s_sx = {{(ENTRY_XLEN-12){imm_s[11]}}, imm_s};

   logic                  legal;
   logic [3:0]            ctrl;
   logic [ENTRY_XLEN-1:0] y_sel;

   // Opcode/funct decode; anything not explicitly matched stays illegal.
   always_comb begin
      legal = 1'b0;
      ctrl  = ADD;
      y_sel = '0;
      case (opcode)
         OP_R: begin
            if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
               y_sel = rs2;
               case (funct3)
                  3'b000: begin
                     legal = 1'b1;
                     ctrl  = funct7[5] ? SUB : ADD;
                  end
                  3'b111: begin
                     legal = 1'b1;
                     ctrl  = AND;
                  end
                  3'b110: begin
                     legal = 1'b1;
                     ctrl  = OR;
                  end
                  default: legal = 1'b0;
               endcase
            end
         end
         OP_I: begin
            y_sel = imm_i_sx;
            case (funct3)
               3'b000: begin
                  legal = 1'b1;
                  ctrl  = ADD;
               end
               3'b111: begin
                  legal = 1'b1;
                  ctrl  = AND;
               end
               3'b110: begin
                  legal = 1'b1;
                  ctrl  = OR;
               end
               default: legal = 1'b0;
            endcase
         end
         OP_LOAD: begin
            legal = 1'b1;
            ctrl  = ADD;
            y_sel = imm_i_sx;
         end
         OP_STORE: begin
            legal = 1'b1;
            ctrl  = ADD;
            y_sel = imm_s_sx;
         end
         OP_BRANCH: begin
            // EX compares via the zero flag of rs1 - rs2.
            legal = 1'b1;
            ctrl  = SUB;
            y_sel = rs2;
         end
         default: legal = 1'b0;
      endcase
   end

   // Assemble the entry; illegal instructions still carry rs1 in x.
   always_comb begin
      entry.x       = rs1;
      entry.y       = legal ? y_sel : '0;
      entry.ctrl    = legal ? ctrl : ILLEGAL_CTRL;
      entry.illegal = ~legal;
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes incoming instructions and queues the resulting
// {x, y, ctrl, illegal} entries in a 2-entry skid buffer toward EX.
// in_ready is registered from occupancy only, so there is no combinational
// path from out_ready back to in_ready. Buffer payload is not reset; the
// outputs are forced to zero whenever the buffer is empty, which also
// hides stale payload during and after reset or flush.
// Optional: define ALU_ISSUE_PERF_EN to add the perf_issued/perf_stall
// saturating counters.
module alu_issue_stage
   import riscv_alu_pkg::*;
#(
   parameter int         XLEN         = 64,  // must match ENTRY_XLEN
   parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_x,
   output logic [XLEN-1:0] alu_y,
   output logic [3:0]      alu_ctrl,
   output logic            out_illegal
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]     perf_issued,
   output logic [31:0]     perf_stall
`endif
);

   issue_entry_t dec_entry;

   alu_ctrl_decode #(
      .ILLEGAL_CTRL (ILLEGAL_CTRL)
   ) u_decode (
      .instr (in_instr),
      .rs1   (in_rs1),
      .rs2   (in_rs2),
      .entry (dec_entry)
   );

   issue_entry_t buf_p0 [2];
   logic [1:0]   cnt;
   logic [1:0]   cnt_nxt;
   logic         wr_ptr;
   logic         rd_ptr;
   logic         in_ready_q;
   logic         push;
   logic         pop;

   assign in_ready  = in_ready_q;
   assign out_valid = (cnt != 2'd0);
   assign push      = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;

   // Occupancy after this edge, ignoring flush (handled in the register).
   always_comb begin
      cnt_nxt = cnt;
      case ({push, pop})
         2'b10:   cnt_nxt = cnt + 2'd1;
         2'b01:   cnt_nxt = cnt - 2'd1;
         default: cnt_nxt = cnt;
      endcase
   end

   // Control state: occupancy, pointers and the registered in_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         in_ready_q <= 1'b0;
      end else if (flush) begin
         cnt        <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         cnt        <= cnt_nxt;
         in_ready_q <= (cnt_nxt < 2'd2);
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
      end
   end

   // Payload storage; a flushed cycle never writes.
   always_ff @(posedge clk) begin
      if (push && !flush) buf_p0[wr_ptr] <= dec_entry;
   end

   issue_entry_t head;
   assign head = buf_p0[rd_ptr];

   // Present the head entry, or zeros while the buffer is empty.
   always_comb begin
      alu_x       = '0;
      alu_y       = '0;
      alu_ctrl    = 4'b0000;
      out_illegal = 1'b0;
      if (out_valid) begin
         alu_x       = head.x;
         alu_y       = head.y;
         alu_ctrl    = head.ctrl;
         out_illegal = head.illegal;
      end
   end

`ifdef ALU_ISSUE_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Saturating issue and stall counters, cleared by reset and flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued <= 32'd0;
         perf_stall  <= 32'd0;
      end else if (flush) begin
         perf_issued <= 32'd0;
         perf_stall  <= 32'd0;
      end else begin
         if (pop)                    perf_issued <= sat_inc(perf_issued);
         if (out_valid && !out_ready) perf_stall <= sat_inc(perf_stall);
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed scenarios plus randomized
// traffic. Accepted instructions push a model-predicted entry into a
// scoreboard queue; a negedge monitor pops and compares on each output
// transfer and checks that a stalled output holds steady.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = 32'd0;
   logic [63:0] in_rs1 = 64'd0;
   logic [63:0] in_rs2 = 64'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] alu_x;
   logic [63:0] alu_y;
   logic [3:0]  alu_ctrl;
   logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_stall;
`endif

   alu_issue_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_x       (alu_x),
      .alu_y       (alu_y),
      .alu_ctrl    (alu_ctrl),
      .out_illegal (out_illegal)
`ifdef ALU_ISSUE_PERF_EN
      ,
      .perf_issued (perf_issued),
      .perf_stall  (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit rand_done = 1'b0;

   typedef struct {
      logic [63:0] x;
      logic [63:0] y;
      logic [3:0]  ctrl;
      logic        ill;
   } exp_t;

   exp_t sb[$];

   // Reference: ALU control and operand selection from the ISA rules.
   function automatic exp_t model(logic [31:0] ins, logic [63:0] a, logic [63:0] b);
      exp_t        e;
      longint      imm_i;
      longint      imm_s;
      logic [6:0]  op;
      logic [6:0]  f7;
      logic [2:0]  f3;
      op    = ins[6:0];
      f3    = ins[14:12];
      f7    = ins[31:25];
      imm_i = longint'($signed(ins[31:20]));
      imm_s = longint'($signed({ins[31:25], ins[11:7]}));
      e.x    = a;
      e.y    = 64'd0;
      e.ctrl = 4'hF;
      e.ill  = 1'b1;
      if (op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7)) begin
         e.ill  = 1'b0;
         e.y    = b;
         e.ctrl = (f3 == 3'd0) ? ((f7 == 7'h20) ? 4'd6 : 4'd2) : ((f3 == 3'd7) ? 4'd0 : 4'd1);
      end else if (op == 7'h13 && (f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7)) begin
         e.ill  = 1'b0;
         e.y    = imm_i;
         e.ctrl = (f3 == 3'd0) ? 4'd2 : ((f3 == 3'd7) ? 4'd0 : 4'd1);
      end else if (op == 7'h03) begin
         e.ill  = 1'b0;
         e.y    = imm_i;
         e.ctrl = 4'd2;
      end else if (op == 7'h23) begin
         e.ill  = 1'b0;
         e.y    = imm_s;
         e.ctrl = 4'd2;
      end else if (op == 7'h63) begin
         e.ill  = 1'b0;
         e.y    = b;
         e.ctrl = 4'd6;
      end
      return e;
   endfunction

   function automatic logic [31:0] r_ins(logic [6:0] f7, logic [2:0] f3);
      return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_ins(logic [11:0] imm, logic [2:0] f3, logic [6:0] op);
      return {imm, 5'd1, f3, 5'd3, op};
   endfunction

   function automatic logic [31:0] s_ins(logic [11:0] imm);
      return {imm[11:5], 5'd2, 5'd1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] rand_ins();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 6))
         0:       return r_ins(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, r[14:12]);
         1:       return r_ins(r[31:25], r[14:12]);
         2:       return i_ins(r[31:20], r[14:12], 7'h13);
         3:       return i_ins(r[31:20], r[14:12], 7'h03);
         4:       return s_ins(r[31:20]);
         5:       return {r[31:7], 7'h63};
         default: return r;
      endcase
   endfunction

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Drive one instruction and wait for it to be accepted (bounded).
   task automatic send(logic [31:0] ins, logic [63:0] a, logic [63:0] b);
      bit done = 1'b0;
      in_instr = ins;
      in_rs1   = a;
      in_rs2   = b;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready && !flush) begin
            sb.push_back(model(ins, a, b));
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout instr=%0h got=not_accepted exp=accepted", ins);
      end
   endtask

   task automatic drain();
      bit empty = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && !empty; i++) begin
         if (sb.size() == 0 && !out_valid) empty = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: compare transfers against the scoreboard, check stall hold.
   exp_t        mon_e;
   logic        prev_stall = 1'b0;
   logic        prev_flush = 1'b0;
   logic [63:0] snap_x;
   logic [63:0] snap_y;
   logic [3:0]  snap_c;
   logic        snap_i;

   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         prev_stall = 1'b0;
         prev_flush = 1'b0;
      end else begin
         if (prev_stall && !prev_flush) begin
            checks++;
            if (!out_valid) begin
               errors++;
               $display("FAIL valid_drop got=0 exp=1");
            end else if (alu_x !== snap_x || alu_y !== snap_y || alu_ctrl !== snap_c || out_illegal !== snap_i) begin
               errors++;
               $display("FAIL hold_stable got x=%0h y=%0h c=%0h i=%0b exp x=%0h y=%0h c=%0h i=%0b",
                        alu_x, alu_y, alu_ctrl, out_illegal, snap_x, snap_y, snap_c, snap_i);
            end
         end
         if (flush) begin
            sb.delete();
         end else if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL spurious_out got x=%0h ctrl=%0h exp=no_entry", alu_x, alu_ctrl);
            end else begin
               mon_e = sb.pop_front();
               if (alu_x !== mon_e.x || alu_y !== mon_e.y || alu_ctrl !== mon_e.ctrl || out_illegal !== mon_e.ill) begin
                  errors++;
                  $display("FAIL out_entry got x=%0h y=%0h c=%0h i=%0b exp x=%0h y=%0h c=%0h i=%0b",
                           alu_x, alu_y, alu_ctrl, out_illegal, mon_e.x, mon_e.y, mon_e.ctrl, mon_e.ill);
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_flush = flush;
         snap_x     = alu_x;
         snap_y     = alu_y;
         snap_c     = alu_ctrl;
         snap_i     = out_illegal;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #3;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_alu_x", alu_x, 64'd0);
      check("rst_alu_y", alu_y, 64'd0);
      check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
      check("rst_illegal", 64'(out_illegal), 64'd0);
`ifdef ALU_ISSUE_PERF_EN
      check("rst_perf_issued", 64'(perf_issued), 64'd0);
      check("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("in_ready_before_edge", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("in_ready_after_edge", 64'(in_ready), 64'd1);

      // Directed decode cases, one-cycle latency
      out_ready = 1'b1;
      send(r_ins(7'h00, 3'b000), 64'd5, 64'd7);
      check("add_valid", 64'(out_valid), 64'd1);
      check("add_ctrl", 64'(alu_ctrl), 64'h2);
      check("add_x", alu_x, 64'd5);
      check("add_y", alu_y, 64'd7);
      send(r_ins(7'h20, 3'b000), 64'd9, 64'd4);
      check("sub_ctrl", 64'(alu_ctrl), 64'h6);
      check("sub_y", alu_y, 64'd4);
      send(i_ins(12'hFFF, 3'b000, 7'h13), 64'd1, 64'd2);
      check("addi_ctrl", 64'(alu_ctrl), 64'h2);
      check("addi_y", alu_y, 64'hFFFF_FFFF_FFFF_FFFF);
      send(s_ins(12'h7FF), 64'd3, 64'd4);
      check("sw_ctrl", 64'(alu_ctrl), 64'h2);
      check("sw_y", alu_y, 64'h7FF);
      send(32'h0000_0073, 64'd8, 64'd9);
      check("ecall_valid", 64'(out_valid), 64'd1);
      check("ecall_ctrl", 64'(alu_ctrl), 64'hF);
      check("ecall_illegal", 64'(out_illegal), 64'd1);
      check("ecall_y", alu_y, 64'd0);
      check("ecall_x", alu_x, 64'd8);
      drain();

      // Backpressure: A, B fill the buffer, C waits
      out_ready = 1'b0;
      send(r_ins(7'h00, 3'b111), 64'h111, 64'h0F0);
      send(r_ins(7'h00, 3'b110), 64'h222, 64'h00F);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_head_x", alu_x, 64'h111);
      fork
         send(i_ins(12'h123, 3'b000, 7'h03), 64'h333, 64'd0);
         begin
            repeat (3) begin
               @(posedge clk);
               #1;
               check("stall_in_ready", 64'(in_ready), 64'd0);
               check("stall_head_x", alu_x, 64'h111);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Flush with two entries and an incoming instruction
      out_ready = 1'b0;
      send(r_ins(7'h00, 3'b000), 64'h44, 64'h1);
      send(r_ins(7'h00, 3'b000), 64'h55, 64'h1);
      in_instr = r_ins(7'h00, 3'b000);
      in_rs1   = 64'hDEAD;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush2_out_valid", 64'(out_valid), 64'd0);
      check("flush2_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("flush2_no_stale", 64'(out_valid), 64'd0);

      // Flush with one entry while the input would be accepted
      out_ready = 1'b0;
      send(r_ins(7'h00, 3'b110), 64'h66, 64'h2);
      in_rs1   = 64'hBEEF;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush1_out_valid", 64'(out_valid), 64'd0);
      check("flush1_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("flush1_no_stale", 64'(out_valid), 64'd0);

      // Randomized traffic with random backpressure
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(rand_ins(), {$urandom, $urandom}, {$urandom, $urandom});
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      drain();

      // Asynchronous reset with two entries buffered
      out_ready = 1'b0;
      send(r_ins(7'h00, 3'b000), 64'h77, 64'h1);
      send(r_ins(7'h00, 3'b000), 64'h88, 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd0);
      check("arst_alu_x", alu_x, 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("arst_no_stale", 64'(out_valid), 64'd0);
`ifdef ALU_ISSUE_PERF_EN
      check("arst_perf_issued", 64'(perf_issued), 64'd0);
      check("arst_perf_stall", 64'(perf_stall), 64'd0);
`endif
      send(r_ins(7'h00, 3'b111), 64'h99, 64'hF);
      check("post_rst_x", alu_x, 64'h99);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue stage that drives the 64-bit ALU interface (x, y, ALUControl) from decoded RISC-V instructions.
- Accepts instruction plus register operands over valid/ready, decodes opcode/funct3/funct7 into the 4-bit ALU control code, and selects operand y as rs2 or a sign-extended immediate.
- Buffers results in a 2-entry skid buffer feeding the EX stage.
- Sits between register-read and the ALU; it is the producer side of the ALU control/operand interface.

Parameters:
- XLEN, 64, operand/result width
- ILLEGAL_CTRL, 4'b1111, ALU control code emitted for undecodable instructions (ALU returns 0)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_rs1  in  XLEN  rs1 data
- in_rs2  in  XLEN  rs2 data
- out_valid  out  1  issue entry valid toward EX
- out_ready  in  1  EX accepts
- alu_x  out  XLEN  ALU operand x (= rs1)
- alu_y  out  XLEN  ALU operand y (rs2 or immediate)
- alu_ctrl  out  4  ALUControl code
- out_illegal  out  1  entry came from an undecodable instruction

Behaviour:
- Reset: asynchronous, active-low on rst_n; the one clock is clk. While rst_n=0: buffer empty, out_valid=0, in_ready=0, alu_x=0, alu_y=0, alu_ctrl=0, out_illegal=0. in_ready rises on the first clk edge after rst_n deasserts.
- Decode, combinational on input:
  - opcode 0110011, R-type: funct3 000 gives 0010 (add) if funct7[5]=0 and 0110 (sub) if funct7[5]=1; 111 gives 0000 (and); 110 gives 0001 (or); y=rs2.
  - opcode 0010011, I-type: funct3 000 gives 0010, 111 gives 0000, 110 gives 0001; y=sext(instr[31:20]).
  - opcode 0000011, load: 0010; y=sext(instr[31:20]).
  - opcode 0100011, store: 0010; y=sext({instr[31:25],instr[11:7]}).
  - opcode 1100011, branch: 0110; y=rs2 (EX uses the zero flag).
  - Anything else, including an unlisted funct3 or R-type funct7 other than 0000000/0100000: alu_ctrl=ILLEGAL_CTRL, out_illegal=1, y=0. The entry still flows; it is not dropped.
- Handshake:
  - Transfer occurs when valid&&ready on a clk edge.
  - Outputs are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer or flush.
- Buffer: 2-entry FIFO of {x, y, ctrl, illegal}.
  - in_ready is registered and equals (count<2), so it is a pure function of occupancy with no combinational path from out_ready.
  - Latency: an entry accepted at edge N into an empty buffer appears with out_valid=1 after edge N.
  - count 1 with push and pop on the same edge: count stays 1; the head advances to the new entry.
  - count 2: in_ready=0; a pop drops count to 1 and in_ready rises after that edge.
  - count 0 with out_ready=1: no effect.
  - Pointers wrap modulo 2.
- Flush, sampled on a clk edge: empties the buffer and discards any same-cycle input transfer, even if in_valid&&in_ready. Flush has priority over push and pop. out_valid=0 and in_ready=1 after the edge. Flush while count=0 is a no-op.
- Reset mid-operation: all entries are lost immediately (asynchronous). No partial state survives.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- Defined: adds outputs perf_issued (32) and perf_stall (32).
  - Both are cleared on reset and on flush.
  - perf_issued increments on each output transfer.
  - perf_stall increments each cycle with out_valid&&!out_ready.
  - Both saturate at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_alu_pkg holds:
  - alu_ctrl_e enum: ADD=4'b0010, SUB=4'b0110, AND=4'b0000, OR=4'b0001
  - opcode localparams: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH
  - issue_entry_t packed struct {x, y, ctrl, illegal}
- Sub-module alu_ctrl_decode (combinational) takes instr, rs1, rs2 and returns an issue_entry_t. The top module holds only the buffer, handshake and flush logic.

Test Plan:
- Reset, then send add x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0010, alu_x=5, alu_y=7.
- Send sub (funct7=0100000); addi with imm=-1; sw with imm=0x7FF -> ctrl 0110 with y=rs2; ctrl 0010 with y=0xFFFF_FFFF_FFFF_FFFF; ctrl 0010 with y=0x7FF.
- Send opcode 1110011 (ecall) -> alu_ctrl=1111, out_illegal=1, y=0, out_valid=1.
- Hold out_ready=0 and send 3 back-to-back instructions -> first two accepted; in_ready=0 after the second; the third is held; outputs stay stable; raising out_ready drains them in order A, B, C.
- Fill 2 entries, then assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the incoming instruction never appears.
- Drop rst_n mid-stream with 2 entries buffered -> out_valid=0 immediately without waiting for a clock edge; after release no stale entry appears. With ALU_ISSUE_PERF_EN defined, both counters read 0.
